// File: rtl/mfp_ahb_ps2_tx_pkg.sv
// Shared constants for the PS/2 host-to-device transmitter: register map,
// STATUS bit positions, FSM encoding and the PS/2 odd-parity helper.
package mfp_ahb_ps2_tx_pkg;

   localparam logic [3:0] H_PS2_TX_DATA_IONUM = 4'd0;
   localparam logic [3:0] H_PS2_TX_STAT_IONUM = 4'd1;
   localparam logic [3:0] H_PS2_TX_CTRL_IONUM = 4'd2;

   localparam int ST_BUSY    = 0;
   localparam int ST_DONE    = 1;
   localparam int ST_ACK     = 2;
   localparam int ST_NACK    = 3;
   localparam int ST_TIMEOUT = 4;
   localparam int ST_OVR     = 5;

   localparam logic [1:0] HTRANS_IDLE = 2'b00;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INHIBIT   = 3'd1,
      S_RTS       = 3'd2,
      S_SHIFT     = 3'd3,
      S_WAIT_IDLE = 3'd4
   } tx_state_e;

   // PS/2 frames use odd parity: the parity bit makes the count of ones odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/mfp_ahb_ps2_tx_sync_edge.sv
// Two-flop synchroniser for an asynchronous PS/2 pin plus a falling-edge strobe.
// Flops reset to 1 (idle line level) so leaving reset never looks like an edge.
module ps2_sync_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic pin_i,
   output logic sync_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= pin_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/mfp_ahb_ps2_tx.sv
// AHB-Lite slave that sends one byte host-to-device over PS/2 using open-drain
// clock/data enables, reporting ack/nack/timeout and an optional interrupt.
module mfp_ahb_ps2_tx
   import mfp_ahb_ps2_tx_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [3:0]  HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic        HSEL,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   input  logic        PS2_CLK_I,
   input  logic        PS2_DAT_I,
   output logic        PS2_CLK_OE,
   output logic        PS2_DAT_OE,
   output logic        TX_BUSY,
   output logic        IRQ
);

   localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
   localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

   // Bus handshake: the slave is always ready (zero wait states). Control is
   // captured in the address phase; a write commits at the end of its data
   // phase using HWDATA, and read data appears in the following data phase.
   logic [3:0]  haddr_q;
   logic [1:0]  htrans_q;
   logic        hwrite_q, hsel_q;
   logic [31:0] hrdata_q, hrdata_d;

   tx_state_e   state_q, state_d;
   logic [19:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0]  bitcnt_q, bitcnt_d;
   logic        dat_oe_q, dat_oe_d;
   logic        clk_oe;
   logic [7:0]  data_q;
   logic        done_q, ack_q, nack_q, timeout_q, ovr_q, irq_en_q;
   logic        done_d, ack_d, nack_d, timeout_d, ovr_d, irq_en_d;
   logic        set_done, set_ack, set_nack, set_to;
   logic        we, wr_data, wr_ctrl, accept, ctrl_clr;
   logic        clk_sync, clk_fall, dat_sync;
   logic        unused_dat_fall;
   logic        unused_hwdata;
   logic [5:0]  status;

   ps2_sync_edge u_clk_sync (
      .clk_i  (HCLK),
      .rst_ni (HRESETn),
      .pin_i  (PS2_CLK_I),
      .sync_o (clk_sync),
      .fall_o (clk_fall)
   );

   ps2_sync_edge u_dat_sync (
      .clk_i  (HCLK),
      .rst_ni (HRESETn),
      .pin_i  (PS2_DAT_I),
      .sync_o (dat_sync),
      .fall_o (unused_dat_fall)
   );

   assign unused_hwdata = ^HWDATA[31:8];

   assign we       = (htrans_q != HTRANS_IDLE) & hsel_q & hwrite_q;
   assign wr_data  = we & (haddr_q == H_PS2_TX_DATA_IONUM);
   assign wr_ctrl  = we & (haddr_q == H_PS2_TX_CTRL_IONUM);
   assign accept   = wr_data & (state_q == S_IDLE);
   assign ctrl_clr = wr_ctrl & HWDATA[0];
   assign cnt_inc  = (cnt_q == 20'hFFFFF) ? cnt_q : cnt_q + 20'd1;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitcnt_d = bitcnt_q;
      dat_oe_d = dat_oe_q;
      clk_oe   = 1'b0;
      set_done = 1'b0;
      set_ack  = 1'b0;
      set_nack = 1'b0;
      set_to   = 1'b0;
      case (state_q)
         S_IDLE: begin
            dat_oe_d = 1'b0;
            if (accept) begin
               state_d = S_INHIBIT;
               cnt_d   = '0;
            end
         end
         S_INHIBIT: begin
            clk_oe = 1'b1;
            if (cnt_q >= INH_LAST) begin
               state_d  = S_RTS;
               dat_oe_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_RTS: begin
            clk_oe   = 1'b1;
            state_d  = S_SHIFT;
            bitcnt_d = '0;
            cnt_d    = '0;
         end
         S_SHIFT: begin
            cnt_d = cnt_inc;
            if (cnt_q >= TO_LAST) begin
               state_d  = S_IDLE;
               dat_oe_d = 1'b0;
               set_to   = 1'b1;
               set_done = 1'b1;
            end else if (clk_fall) begin
               bitcnt_d = bitcnt_q + 4'd1;
               if (bitcnt_q < 4'd8) begin
                  dat_oe_d = ~data_q[bitcnt_q[2:0]];
               end else if (bitcnt_q == 4'd8) begin
                  dat_oe_d = ~odd_parity(data_q);
               end else if (bitcnt_q == 4'd9) begin
                  dat_oe_d = 1'b0;
               end else begin
                  // 11th fall: the device answers by pulling data low to ack.
                  set_ack  = ~dat_sync;
                  set_nack = dat_sync;
                  state_d  = S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            cnt_d = cnt_inc;
            if (cnt_q >= TO_LAST) begin
               state_d  = S_IDLE;
               dat_oe_d = 1'b0;
               set_to   = 1'b1;
               set_done = 1'b1;
            end else if (clk_sync && dat_sync) begin
               state_d  = S_IDLE;
               set_done = 1'b1;
            end
         end
         default: begin
            state_d  = S_IDLE;
            dat_oe_d = 1'b0;
         end
      endcase
   end

   // Flag updates: a set from the FSM wins over a same-cycle CTRL clear.
   always_comb begin
      done_d    = done_q;
      ack_d     = ack_q;
      nack_d    = nack_q;
      timeout_d = timeout_q;
      ovr_d     = ovr_q;
      irq_en_d  = irq_en_q;
      if (accept || ctrl_clr) begin
         done_d    = 1'b0;
         ack_d     = 1'b0;
         nack_d    = 1'b0;
         timeout_d = 1'b0;
      end
      if (ctrl_clr)                       ovr_d    = 1'b0;
      if (wr_ctrl)                        irq_en_d = HWDATA[1];
      if (set_done)                       done_d    = 1'b1;
      if (set_ack)                        ack_d     = 1'b1;
      if (set_nack)                       nack_d    = 1'b1;
      if (set_to)                         timeout_d = 1'b1;
      if (wr_data && state_q != S_IDLE)   ovr_d     = 1'b1;
   end

   assign status = {ovr_q, timeout_q, nack_q, ack_q, done_q, TX_BUSY};

   always_comb begin
      hrdata_d = '0;
      case (HADDR)
         H_PS2_TX_DATA_IONUM: hrdata_d = {24'b0, data_q};
         H_PS2_TX_STAT_IONUM: hrdata_d = {26'b0, status};
         H_PS2_TX_CTRL_IONUM: hrdata_d = {30'b0, irq_en_q, 1'b0};
         default:             hrdata_d = '0;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         haddr_q   <= '0;
         htrans_q  <= HTRANS_IDLE;
         hwrite_q  <= 1'b0;
         hsel_q    <= 1'b0;
         hrdata_q  <= '0;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bitcnt_q  <= '0;
         dat_oe_q  <= 1'b0;
         data_q    <= '0;
         done_q    <= 1'b0;
         ack_q     <= 1'b0;
         nack_q    <= 1'b0;
         timeout_q <= 1'b0;
         ovr_q     <= 1'b0;
         irq_en_q  <= 1'b0;
      end else begin
         haddr_q   <= HADDR;
         htrans_q  <= HTRANS;
         hwrite_q  <= HWRITE;
         hsel_q    <= HSEL;
         hrdata_q  <= hrdata_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bitcnt_q  <= bitcnt_d;
         dat_oe_q  <= dat_oe_d;
         if (accept) data_q <= HWDATA[7:0];
         done_q    <= done_d;
         ack_q     <= ack_d;
         nack_q    <= nack_d;
         timeout_q <= timeout_d;
         ovr_q     <= ovr_d;
         irq_en_q  <= irq_en_d;
      end
   end

   assign HRDATA     = hrdata_q;
   assign PS2_CLK_OE = clk_oe;
   assign PS2_DAT_OE = dat_oe_q;
   assign TX_BUSY    = (state_q != S_IDLE);
   assign IRQ        = done_q & irq_en_q;

endmodule
